vend_txn_sequencer: RTL and testbench

Transaction sequencer for the vending machine datapath. Takes decoded coin value and product price, debounced button levels and a 1 Hz tick strobe, and sequences collect -> confirm -> dispense/alarm -> change/refund. Owns the coin accumulator, change register, sales-total accumulator and the timed dispense/alarm indications. Sits between the code-to-value decoders and the display modules.

---
 rtl/vend_txn_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_vend_txn_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vend_txn_sequencer.sv
// Vending machine transaction sequencer: collect -> confirm -> dispense/alarm -> change/refund.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   tick                   one-clk 1 Hz strobe
//   coin_btn/confirm_btn/cancel_btn  button levels (only rising edges act)
//   sales_clear            synchronous clear of sales_total
//   coin_value, product_price  decoded coin value and product price
//   coin_total, change, sales_total  credit, change/refund shown, cumulative sales
//   product_dispensed, alarm, busy    timed indications
//   state                  current state encoding
module vend_txn_sequencer #(
  parameter int unsigned HOLD_TICKS    = 3,
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       coin_btn,
  input  logic       confirm_btn,
  input  logic       cancel_btn,
  input  logic       sales_clear,
  input  logic [7:0] coin_value,
  input  logic [7:0] product_price,
  output logic [7:0] coin_total,
  output logic [7:0] change,
  output logic [7:0] sales_total,
  output logic       product_dispensed,
  output logic       alarm,
  output logic       busy,
  output logic [2:0] state
);

  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_DISPENSE = 3'd2,
    S_ALARM    = 3'd3,
    S_REFUND   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      coin_q, coin_d;
  logic [7:0]      change_q, change_d;
  logic [7:0]      sales_q, sales_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic            coin_btn_q, confirm_btn_q, cancel_btn_q;
  logic            disp_q, alarm_q, busy_q;

  logic            coin_press, confirm_press, cancel_press;
  logic            act_coin, act_confirm, act_cancel;
  logic [8:0]      coin_sum, sales_sum;
  logic            hold_done, idle_done;

  // Rising-edge detect with cancel > confirm > coin priority
  assign coin_press    = coin_btn & ~coin_btn_q;
  assign confirm_press = confirm_btn & ~confirm_btn_q;
  assign cancel_press  = cancel_btn & ~cancel_btn_q;
  assign act_cancel    = cancel_press;
  assign act_confirm   = confirm_press & ~cancel_press;
  assign act_coin      = coin_press & ~confirm_press & ~cancel_press;

  assign coin_sum  = {1'b0, coin_q} + {1'b0, coin_value};
  assign sales_sum = {1'b0, sales_q} + {1'b0, product_price};
  assign hold_done = tick && (hold_q == HW'(HOLD_TICKS - 1));
  assign idle_done = tick && (idle_q == TW'(TIMEOUT_TICKS - 1));

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    coin_d   = coin_q;
    change_d = change_q;
    sales_d  = sales_q;
    hold_d   = hold_q;
    idle_d   = idle_q;
    case (state_q)
      S_IDLE: begin
        if (act_coin && coin_value != 8'd0) begin
          coin_d  = coin_value;
          idle_d  = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (act_cancel || (!act_confirm && !act_coin && idle_done)) begin
          change_d = coin_q;
          coin_d   = 8'd0;
          hold_d   = '0;
          state_d  = S_REFUND;
        end else if (act_confirm) begin
          hold_d = '0;
          if (product_price != 8'd0 && coin_q >= product_price) begin
            change_d = coin_q - product_price;
            coin_d   = 8'd0;
            sales_d  = sales_sum[8] ? 8'hFF : sales_sum[7:0];
            state_d  = S_DISPENSE;
          end else begin
            state_d = S_ALARM;
          end
        end else if (act_coin) begin
          coin_d = coin_sum[8] ? 8'hFF : coin_sum[7:0];
          idle_d = '0;
        end else if (tick) begin
          idle_d = idle_q + TW'(1);
        end
      end
      S_DISPENSE, S_REFUND: begin
        if (hold_done) begin
          change_d = 8'd0;
          state_d  = S_IDLE;
        end else if (tick) begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_ALARM: begin
        if (cancel_press) begin
          change_d = coin_q;
          coin_d   = 8'd0;
          hold_d   = '0;
          state_d  = S_REFUND;
        end else if (hold_done) begin
          idle_d  = '0;
          state_d = S_COLLECT;
        end else if (tick) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        coin_d   = 8'd0;
        change_d = 8'd0;
        sales_d  = 8'd0;
        hold_d   = '0;
        idle_d   = '0;
      end
    endcase
    if (sales_clear) sales_d = 8'd0;
  end

  // State, datapath and registered indications
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      coin_q        <= 8'd0;
      change_q      <= 8'd0;
      sales_q       <= 8'd0;
      hold_q        <= '0;
      idle_q        <= '0;
      coin_btn_q    <= 1'b0;
      confirm_btn_q <= 1'b0;
      cancel_btn_q  <= 1'b0;
      disp_q        <= 1'b0;
      alarm_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      coin_q        <= coin_d;
      change_q      <= change_d;
      sales_q       <= sales_d;
      hold_q        <= hold_d;
      idle_q        <= idle_d;
      coin_btn_q    <= coin_btn;
      confirm_btn_q <= confirm_btn;
      cancel_btn_q  <= cancel_btn;
      disp_q        <= (state_d == S_DISPENSE);
      alarm_q       <= (state_d == S_ALARM);
      busy_q        <= (state_d == S_DISPENSE) || (state_d == S_ALARM) ||
                       (state_d == S_REFUND);
    end
  end

  assign coin_total        = coin_q;
  assign change            = change_q;
  assign sales_total       = sales_q;
  assign product_dispensed = disp_q;
  assign alarm             = alarm_q;
  assign busy              = busy_q;
  assign state             = state_q;

endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Directed self-checking bench for vend_txn_sequencer (default parameters).
module tb_vend_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, coin_btn, confirm_btn, cancel_btn, sales_clear;
  logic [7:0] coin_value, product_price;
  logic [7:0] coin_total, change, sales_total;
  logic       product_dispensed, alarm, busy;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  vend_txn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .coin_btn(coin_btn), .confirm_btn(confirm_btn), .cancel_btn(cancel_btn),
    .sales_clear(sales_clear), .coin_value(coin_value), .product_price(product_price),
    .coin_total(coin_total), .change(change), .sales_total(sales_total),
    .product_dispensed(product_dispensed), .alarm(alarm), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given button/tick levels, then one quiet clock to re-arm edge detect
  task automatic pulse(input logic c, input logic f, input logic x, input logic t);
    coin_btn = c; confirm_btn = f; cancel_btn = x; tick = t;
    step();
    coin_btn = 0; confirm_btn = 0; cancel_btn = 0; tick = 0; sales_clear = 0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(0, 0, 0, 1);
  endtask

  task automatic coin(input int v);
    coin_value = 8'(v);
    pulse(1, 0, 0, 0);
  endtask

  task automatic expect_state(input string tag, input int st, input int ct, input int ch,
                              input int disp, input int alm, input int bsy);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".coin"}, int'(coin_total), ct);
    chk({tag, ".change"}, int'(change), ch);
    chk({tag, ".disp"}, int'(product_dispensed), disp);
    chk({tag, ".alarm"}, int'(alarm), alm);
    chk({tag, ".busy"}, int'(busy), bsy);
  endtask

  initial begin
    rst_n = 0; tick = 0; coin_btn = 0; confirm_btn = 0; cancel_btn = 0;
    sales_clear = 0; coin_value = 0; product_price = 0;
    step(); step();
    expect_state("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.sales", int'(sales_total), 0);
    rst_n = 1;
    step();

    // Basic purchase: 5 + 5, price 8
    product_price = 8;
    coin(5);
    expect_state("buy.c1", 1, 5, 0, 0, 0, 0);
    coin(5);
    chk("buy.c2", int'(coin_total), 10);
    pulse(0, 1, 0, 0);
    expect_state("buy.disp", 2, 0, 2, 1, 0, 1);
    chk("buy.sales", int'(sales_total), 8);
    ticks(2);
    expect_state("buy.hold2", 2, 0, 2, 1, 0, 1);
    ticks(1);
    expect_state("buy.done", 0, 0, 0, 0, 0, 0);

    // Insufficient credit -> alarm, then top up
    coin(3);
    pulse(0, 1, 0, 0);
    expect_state("alm.enter", 3, 3, 0, 0, 1, 1);
    pulse(1, 0, 0, 0);
    chk("alm.coin_ignored", int'(coin_total), 3);
    ticks(2);
    chk("alm.hold2", int'(state), 3);
    ticks(1);
    expect_state("alm.exit", 1, 3, 0, 0, 0, 0);
    coin(5);
    chk("alm.topup", int'(coin_total), 8);
    pulse(0, 1, 0, 0);
    expect_state("alm.disp", 2, 0, 0, 1, 0, 1);
    chk("alm.sales", int'(sales_total), 16);
    ticks(3);
    chk("alm.idle", int'(state), 0);

    // Saturating credit, cancel refund
    coin(200);
    coin(100);
    chk("sat.coin", int'(coin_total), 255);
    pulse(0, 0, 1, 0);
    expect_state("sat.refund", 4, 0, 255, 0, 0, 1);
    ticks(3);
    expect_state("sat.idle", 0, 0, 0, 0, 0, 0);

    // Inactivity timeout
    coin(4);
    ticks(9);
    chk("to.tick9", int'(state), 1);
    ticks(1);
    expect_state("to.refund", 4, 0, 4, 0, 0, 1);
    ticks(3);
    chk("to.idle", int'(state), 0);

    // Cancel beats confirm in the same clock
    product_price = 5;
    coin(6);
    pulse(0, 1, 1, 0);
    expect_state("prio.refund", 4, 0, 6, 0, 0, 1);
    chk("prio.sales", int'(sales_total), 16);
    ticks(3);

    // Held coin button acts once
    coin_value = 7; coin_btn = 1;
    for (int i = 0; i < 5; i++) step();
    coin_btn = 0;
    step();
    chk("held.coin", int'(coin_total), 7);
    pulse(0, 1, 0, 0);
    expect_state("held.disp", 2, 0, 2, 1, 0, 1);
    chk("held.sales", int'(sales_total), 21);
    ticks(3);

    // Reach 250, then saturate sales; tick in the entry clock is not counted
    product_price = 229;
    coin(229);
    pulse(0, 1, 0, 0);
    chk("sales.250", int'(sales_total), 250);
    ticks(3);
    product_price = 10;
    coin(10);
    pulse(0, 1, 0, 1);
    chk("sales.255", int'(sales_total), 255);
    ticks(2);
    chk("entry_tick.hold", int'(state), 2);
    ticks(1);
    chk("entry_tick.idle", int'(state), 0);

    // sales_clear overrides a same-cycle accumulate
    coin(10);
    sales_clear = 1;
    pulse(0, 1, 0, 0);
    chk("clr.sales", int'(sales_total), 0);
    chk("clr.state", int'(state), 2);

    // Async reset mid-DISPENSE
    #2;
    rst_n = 0;
    #1;
    expect_state("arst", 0, 0, 0, 0, 0, 0);
    chk("arst.sales", int'(sales_total), 0);
    step();
    rst_n = 1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
